// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for a small pipelined core.
//   Picks the next fetch address each cycle (halt > jump > branch > stall > PC+4),
//   tracks a one-cycle REDIRECT state after a taken jump/branch and a HALT state
//   released by resume, and keeps sticky/saturating status.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   stall                  hold the PC (lowest-priority control)
//   branch_taken/_target   taken branch from ID and its destination
//   jump/jump_target       unconditional jump from ID and its destination
//   halt, resume           enter HALT (break/syscall); one-cycle release from HALT
//   PC                     fetch address
//   IF_Flush               fetch must latch a NOP this cycle (combinational)
//   align_err              sticky: an accepted redirect had a misaligned raw target
//   fetch_count            saturating count of PC updates / accepted redirects
//   flush_count            saturating count of IF_Flush cycles
module pc_sequencer #(
  parameter int unsigned     PC_W     = 6,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            halt,
  input  logic            resume,
  output logic [PC_W-1:0] PC,
  output logic            IF_Flush,
  output logic            align_err,
  output logic [15:0]     fetch_count,
  output logic [7:0]      flush_count
);

  typedef enum logic [1:0] {
    S_RUN,
    S_REDIRECT,
    S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] raw_target;
  logic            redirect;
  logic            flush_int;
  logic            fetch_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    raw_target = '0;
    redirect   = 1'b0;
    flush_int  = 1'b0;
    case (state_q)
      S_HALT: begin
        flush_int = 1'b1;
        if (resume) begin
          pc_d    = pc_q + PC_W'(4);
          state_d = S_RUN;
        end
      end
      default: begin
        // RUN and REDIRECT share the same next-PC rules; REDIRECT only
        // differs in that it falls back to RUN when nothing new happens.
        flush_int = jump | branch_taken | halt;
        if (halt) begin
          state_d = S_HALT;
        end else if (jump) begin
          redirect   = 1'b1;
          raw_target = jump_target;
        end else if (branch_taken) begin
          redirect   = 1'b1;
          raw_target = branch_target;
        end else begin
          state_d = S_RUN;
          if (!stall) pc_d = pc_q + PC_W'(4);
        end
        if (redirect) begin
          pc_d    = {raw_target[PC_W-1:2], 2'b00};
          state_d = S_REDIRECT;
        end
      end
    endcase
  end

  // A redirect to the current PC still counts as a fetch update.
  assign fetch_inc = (pc_d != pc_q) | redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err   <= 1'b0;
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (redirect && (raw_target[1:0] != 2'b00)) align_err <= 1'b1;
      if (fetch_inc && (fetch_count != '1)) fetch_count <= fetch_count + 16'd1;
      if (flush_int && (flush_count != '1)) flush_count <= flush_count + 8'd1;
    end
  end

  assign PC       = pc_q;
  assign IF_Flush = rst_n & flush_int;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, halt = 1'b0, resume = 1'b0;
  logic [5:0] branch_target = '0, jump_target = '0;
  logic [5:0] PC;
  logic       IF_Flush, align_err;
  logic [15:0] fetch_count;
  logic [7:0]  flush_count;

  int tests = 0;
  int fails = 0;

  // Reference model state (plain integers, PC kept modulo 64).
  int m_pc, m_fetch, m_flush;
  bit m_halted, m_align, exp_flush;

  pc_sequencer #(.PC_W(6), .RESET_PC(6'd0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .halt(halt), .resume(resume),
    .PC(PC), .IF_Flush(IF_Flush), .align_err(align_err),
    .fetch_count(fetch_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; jump = 0; halt = 0; resume = 0;
    branch_target = '0; jump_target = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    m_pc = 0; m_fetch = 0; m_flush = 0; m_halted = 0; m_align = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advances the model by one clock edge using the current inputs; exp_flush is
  // what IF_Flush must show in the cycle before that edge.
  task automatic model_edge();
    int  nxt;
    int  tgt;
    bit  redir;
    nxt   = m_pc;
    redir = 0;
    tgt   = 0;
    exp_flush = m_halted ? 1'b1 : (jump | branch_taken | halt);
    if (m_halted) begin
      if (resume) begin
        nxt = (m_pc + 4) % 64;
        m_halted = 0;
      end
    end else if (halt) begin
      m_halted = 1;
    end else if (jump || branch_taken) begin
      redir = 1;
      tgt   = jump ? int'(jump_target) : int'(branch_target);
      nxt   = tgt - (tgt % 4);
      if (tgt % 4 != 0) m_align = 1;
    end else if (!stall) begin
      nxt = (m_pc + 4) % 64;
    end
    if ((nxt != m_pc || redir) && m_fetch < 65535) m_fetch++;
    if (exp_flush && m_flush < 255) m_flush++;
    m_pc = nxt;
  endtask

  task automatic test_reset();
    branch_taken = 1; jump = 1; halt = 1;
    #2;
    tests++;
    if (PC !== 6'd0 || IF_Flush !== 1'b0 || align_err !== 1'b0 ||
        fetch_count !== 16'd0 || flush_count !== 8'd0) begin
      fails++;
      $display("FAIL reset_state: PC=%0d IF_Flush=%b align=%b fetch=%0d flush=%0d, want 0/0/0/0/0",
               PC, IF_Flush, align_err, fetch_count, flush_count);
    end
    do_reset();
    step();
    tests++;
    if (PC !== 6'd4) begin
      fails++;
      $display("FAIL first_update: PC=%0d want 4", PC);
    end
  endtask

  task automatic test_free_run();
    do_reset();
    for (int unsigned i = 1; i <= 16; i++) begin
      #1;
      tests++;
      if (IF_Flush !== 1'b0) begin
        fails++;
        $display("FAIL free_flush: cycle %0d IF_Flush=%b want 0", i, IF_Flush);
      end
      step();
      tests++;
      if (PC !== 6'((4 * i) % 64)) begin
        fails++;
        $display("FAIL free_pc: cycle %0d PC=%0d want %0d", i, PC, (4 * i) % 64);
      end
    end
    tests++;
    if (fetch_count !== 16'd16) begin
      fails++;
      $display("FAIL free_fetch_count: got %0d want 16", fetch_count);
    end
  endtask

  task automatic test_branch();
    do_reset();
    step(); step();
    branch_taken = 1; branch_target = 6'd32;
    #1;
    tests++;
    if (PC !== 6'd8 || IF_Flush !== 1'b1) begin
      fails++;
      $display("FAIL branch_flush: PC=%0d IF_Flush=%b want 8/1", PC, IF_Flush);
    end
    step();
    clear_inputs();
    tests++;
    if (PC !== 6'd32 || flush_count !== 8'd1) begin
      fails++;
      $display("FAIL branch_target: PC=%0d flush=%0d want 32/1", PC, flush_count);
    end
    step();
    tests++;
    if (PC !== 6'd36 || IF_Flush !== 1'b0) begin
      fails++;
      $display("FAIL branch_after: PC=%0d IF_Flush=%b want 36/0", PC, IF_Flush);
    end
  endtask

  task automatic test_stall_jump();
    do_reset();
    step(); step(); step();
    stall = 1; jump = 1; jump_target = 6'd20;
    step();
    jump = 0;
    tests++;
    if (PC !== 6'd20) begin
      fails++;
      $display("FAIL stall_jump: PC=%0d want 20", PC);
    end
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      tests++;
      if (PC !== 6'd20) begin
        fails++;
        $display("FAIL stall_hold: cycle %0d PC=%0d want 20", i, PC);
      end
    end
    stall = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    branch_taken = 1; branch_target = 6'd40;
    #1;
    step();
    clear_inputs();
    jump = 1; jump_target = 6'd8;
    #1;
    tests++;
    if (PC !== 6'd40 || IF_Flush !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: PC=%0d IF_Flush=%b want 40/1", PC, IF_Flush);
    end
    step();
    clear_inputs();
    tests++;
    if (PC !== 6'd8 || flush_count !== 8'd2 || fetch_count !== 16'd2) begin
      fails++;
      $display("FAIL b2b_second: PC=%0d flush=%0d fetch=%0d want 8/2/2", PC, flush_count, fetch_count);
    end
    step();
    tests++;
    if (PC !== 6'd12) begin
      fails++;
      $display("FAIL b2b_return: PC=%0d want 12", PC);
    end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (4) step();
    halt = 1;
    #1;
    tests++;
    if (PC !== 6'd16 || IF_Flush !== 1'b1) begin
      fails++;
      $display("FAIL halt_cycle: PC=%0d IF_Flush=%b want 16/1", PC, IF_Flush);
    end
    step();
    halt = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      stall = 1'($urandom); jump = 1'($urandom); branch_taken = 1'($urandom);
      jump_target = 6'($urandom); branch_target = 6'($urandom);
      #1;
      tests++;
      if (PC !== 6'd16 || IF_Flush !== 1'b1) begin
        fails++;
        $display("FAIL halt_hold: cycle %0d PC=%0d IF_Flush=%b want 16/1", i, PC, IF_Flush);
      end
      step();
    end
    clear_inputs();
    resume = 1;
    step();
    resume = 0;
    #1;
    tests++;
    if (PC !== 6'd20 || IF_Flush !== 1'b0 || flush_count !== 8'd7) begin
      fails++;
      $display("FAIL halt_resume: PC=%0d IF_Flush=%b flush=%0d want 20/0/7", PC, IF_Flush, flush_count);
    end
  endtask

  task automatic test_align();
    do_reset();
    branch_taken = 1; branch_target = 6'h0E;
    step();
    clear_inputs();
    tests++;
    if (PC !== 6'd12 || align_err !== 1'b1) begin
      fails++;
      $display("FAIL align_set: PC=%0d align=%b want 12/1", PC, align_err);
    end
    // resume outside HALT must not disturb normal sequencing
    resume = 1;
    for (int unsigned i = 1; i <= 5; i++) begin
      step();
      tests++;
      if (align_err !== 1'b1 || PC !== 6'((12 + 4 * i) % 64)) begin
        fails++;
        $display("FAIL align_sticky: cycle %0d PC=%0d align=%b want %0d/1", i, PC, align_err, (12 + 4 * i) % 64);
      end
    end
    resume = 0;
    #2;
    rst_n = 0;
    #1;
    tests++;
    if (align_err !== 1'b0) begin
      fails++;
      $display("FAIL align_clear: align=%b want 0", align_err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) step();
    halt = 1;
    step();
    halt = 0;
    step();
    #3;
    rst_n = 0;
    #1;
    tests++;
    if (PC !== 6'd0 || IF_Flush !== 1'b0 || fetch_count !== 16'd0 || flush_count !== 8'd0) begin
      fails++;
      $display("FAIL async_reset_halt: PC=%0d IF_Flush=%b fetch=%0d flush=%0d want 0/0/0/0",
               PC, IF_Flush, fetch_count, flush_count);
    end
    do_reset();
    step();
    tests++;
    if (PC !== 6'd4 || IF_Flush !== 1'b0) begin
      fails++;
      $display("FAIL after_halt_reset: PC=%0d IF_Flush=%b want 4/0", PC, IF_Flush);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int unsigned i = 0; i < 800; i++) begin
      stall         = ($urandom_range(3) == 0);
      jump          = ($urandom_range(7) == 0);
      branch_taken  = ($urandom_range(5) == 0);
      halt          = ($urandom_range(11) == 0);
      resume        = ($urandom_range(3) == 0);
      jump_target   = 6'($urandom);
      branch_target = 6'($urandom);
      #1;
      model_edge();
      tests++;
      if (IF_Flush !== exp_flush) begin
        fails++;
        $display("FAIL rand_flush: cycle %0d IF_Flush=%b want %b", i, IF_Flush, exp_flush);
      end
      step();
      tests++;
      if (PC !== 6'(m_pc) || align_err !== m_align ||
          fetch_count !== 16'(m_fetch) || flush_count !== 8'(m_flush)) begin
        fails++;
        $display("FAIL rand_state: cycle %0d PC=%0d align=%b fetch=%0d flush=%0d want %0d/%b/%0d/%0d",
                 i, PC, align_err, fetch_count, flush_count, m_pc, m_align, m_fetch, m_flush);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_branch();
    test_stall_jump();
    test_back_to_back();
    test_halt();
    test_align();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
